user_uart_tx: RTL and testbench

// - Synthesizable 8N1 UART transmitter in the user project area. Drives mprj_io[6] so firmware/LA

---
 rtl/user_uart_tx.sv | 233 +++++++++++++++++++++++
 tb/tb_user_uart_tx.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/user_uart_tx.sv
// -----------------------------------------------------------------------------
// user_uart_tx
// UART transmitter for the user project area. It drives mprj_io[6] so that
// firmware and logic-analyzer results reach the testbench UART receiver.
// A producer pushes bytes into a small FIFO over a valid/ready port. A frame
// FSM sends each byte LSB-first. The bit period is programmed at runtime.
//
// Build option:
//   UART_TX_PARITY_EN : when defined, one even-parity bit is inserted between
//                       data bit 7 and the stop bit (8E1). When undefined the
//                       frame is 8N1 and the PARITY state does not exist.
//
// Parameters:
//   FIFO_DEPTH : number of byte entries in the TX FIFO (power of 2, >= 2)
//   DIV_W      : width of clk_div
//
// Ports:
//   wb_clk_i   in   system clock
//   wb_rst_i   in   asynchronous, active-high reset
//   clk_div    in   bit period in wb_clk_i cycles; values below 2 act as 2
//   tx_data    in   byte to send
//   tx_valid   in   producer has a byte on tx_data
//   tx_ready   out  FIFO can accept a byte (not full)
//   tx         out  serial line, idle high, registered
//   busy       out  a frame is in progress or the FIFO is not empty
//   fifo_level out  current FIFO occupancy
// -----------------------------------------------------------------------------
module user_uart_tx #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic [DIV_W-1:0]              clk_div,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // ---------------------------------------------------------------- FIFO
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic [7:0]  rd_data;

    // Pointers carry one extra wrap bit. Equal low bits with different wrap
    // bits means the FIFO is full.
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign push     = tx_valid && !full;
    assign rd_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign tx_ready = !full;
    assign fifo_level = wr_ptr_q - rd_ptr_q;

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= tx_data;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // ---------------------------------------------------------------- frame FSM
    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic [DIV_W-1:0] div_clamped;
    logic             bit_done;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    assign div_clamped = (clk_div < DIV_W'(2)) ? DIV_W'(2) : clk_div;
    // The baud counter runs from div_q-1 down to 0. Zero marks the last cycle
    // of the current bit.
    assign bit_done    = (cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    // clk_div is sampled only here and at a back-to-back pop,
                    // so a change never disturbs a frame already in flight.
                    pop      = 1'b1;
                    div_d    = div_clamped;
                    cnt_d    = div_clamped - DIV_W'(1);
                    shift_d  = rd_data;
                    tx_d     = 1'b0;
                    state_d  = S_START;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^rd_data;
`endif
                end
            end
            S_START: begin
                if (bit_done) begin
                    cnt_d     = div_q - DIV_W'(1);
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                    state_d   = S_DATA;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    cnt_d = div_q - DIV_W'(1);
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = S_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_done) begin
                    cnt_d   = div_q - DIV_W'(1);
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (bit_done) begin
                    if (!empty) begin
                        // Chain straight into the next start bit with no idle gap.
                        pop      = 1'b1;
                        div_d    = div_clamped;
                        cnt_d    = div_clamped - DIV_W'(1);
                        shift_d  = rd_data;
                        tx_d     = 1'b0;
                        state_d  = S_START;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^rd_data;
`endif
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            div_q     <= DIV_W'(2);
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_user_uart_tx.sv
`timescale 1ns/1ps
module tb_user_uart_tx;

    localparam int FIFO_DEPTH = 8;
    localparam int DIV_W      = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [DIV_W-1:0] clk_div;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             tx;
    logic             busy;
    logic [3:0]       fifo_level;

    user_uart_tx #(.FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .clk_div    (clk_div),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #12.5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        int         div;
    } exp_t;
    exp_t sb[$];

    logic mon_en   = 1'b0;
    logic mon_busy = 1'b0;
    int   frames   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_edge(input int n);
        while (cyc < n) step();
    endtask

    task automatic push1(input logic [7:0] b, input int div, output int edge_no);
        exp_t e;
        e.data = b;
        e.div  = div;
        sb.push_back(e);
        tx_valid = 1'b1;
        tx_data  = b;
        step();
        edge_no  = cyc;
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while ((busy !== 1'b0 || mon_busy) && n < max_cyc) begin
            step();
            n++;
        end
        chk("idle_within_bound", 32'(n < max_cyc), 32'd1);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    // Serial-line monitor: decodes each frame at the expected bit period and
    // compares it with the scoreboard head.
    initial begin
        exp_t       e;
        logic       bits [NBITS];
        logic [7:0] obs;
        logic       ok;
        logic       aborted;
        forever begin
            @(negedge clk);
            if (mon_en && !rst && tx === 1'b0) begin
                mon_busy = 1'b1;
                if (sb.size() == 0) begin
                    chk("unexpected_frame", 32'(sb.size()), 32'd1);
                    for (int k = 0; k < 2000 && tx !== 1'b1; k++) @(negedge clk);
                end else begin
                    e = sb.pop_front();
                    bits[0] = 1'b0;
                    for (int i = 0; i < 8; i++) bits[1+i] = e.data[i];
`ifdef UART_TX_PARITY_EN
                    bits[9] = ^e.data;
`endif
                    bits[NBITS-1] = 1'b1;
                    ok = 1'b1;
                    aborted = 1'b0;
                    obs = 8'h00;
                    for (int b = 0; b < NBITS && !aborted; b++) begin
                        for (int c = 0; c < e.div && !aborted; c++) begin
                            if (!(b == 0 && c == 0)) @(negedge clk);
                            if (rst) aborted = 1'b1;
                            if (tx !== bits[b]) ok = 1'b0;
                            if (b >= 1 && b <= 8 && c == e.div / 2) obs[b-1] = tx;
                        end
                    end
                    if (!aborted) begin
                        chk("frame_byte", 32'(obs), 32'(e.data));
                        chk("frame_bit_timing", 32'(ok), 32'd1);
                        frames++;
                    end
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        int         e0;
        int         f0;
        int         i;
        int         guard;
        logic       rdy;
        logic [7:0] bytes [10];
        exp_t       e;

        rst      = 1'b1;
        clk_div  = DIV_W'(4);
        tx_data  = 8'h00;
        tx_valid = 1'b0;

        // Reset held three cycles
        repeat (3) step();
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        rst = 1'b0;
        step();
        mon_en = 1'b1;

        // Single byte at divisor 4
        f0 = frames;
        push1(8'hA5, 4, e0);
        chk("single_level_after_push", 32'(fifo_level), 32'd1);
        chk("single_tx_idle_at_push", 32'(tx), 32'd1);
        step();
        chk("single_start_bit_latency", 32'(tx), 32'd0);
        chk("single_level_after_pop", 32'(fifo_level), 32'd0);
        wait_edge(e0 + NBITS * 4);
        chk("single_busy_last_cycle", 32'(busy), 32'd1);
        step();
        chk("single_busy_fall", 32'(busy), 32'd0);
        chk("single_tx_idle_after", 32'(tx), 32'd1);
        wait_idle(200);
        chk("single_frame_count", 32'(frames - f0), 32'd1);

`ifdef UART_TX_PARITY_EN
        // Odd-weight byte gives a parity bit of 1
        f0 = frames;
        push1(8'h01, 4, e0);
        wait_edge(e0 + NBITS * 4);
        chk("parity_busy_last_cycle", 32'(busy), 32'd1);
        step();
        chk("parity_busy_fall", 32'(busy), 32'd0);
        wait_idle(200);
        chk("parity_frame_count", 32'(frames - f0), 32'd1);
`endif

        // Ten bytes offered every cycle: FIFO fills, frames chain
        f0 = frames;
        clk_div = DIV_W'(4);
        for (int k = 0; k < 10; k++) begin
            bytes[k] = 8'h30 + 8'(k * 7);
            e.data = bytes[k];
            e.div  = 4;
            sb.push_back(e);
        end
        i = 0;
        guard = 0;
        e0 = -1;
        tx_valid = 1'b1;
        tx_data  = bytes[0];
        while (i < 10 && guard < 200) begin
            rdy = tx_ready;
            step();
            guard++;
            if (e0 < 0) e0 = cyc;
            if (rdy) begin
                i++;
                if (i < 10) tx_data = bytes[i];
            end
            if (cyc == e0 + 8) begin
                chk("full_ready_low", 32'(tx_ready), 32'd0);
                chk("full_level", 32'(fifo_level), 32'd8);
            end
            if (cyc == e0 + 40) begin
                chk("full_ready_still_low", 32'(tx_ready), 32'd0);
            end
        end
        tx_valid = 1'b0;
        chk("full_all_accepted", 32'(i), 32'd10);
        chk("full_last_waited", 32'(cyc - e0 > 40), 32'd1);
        wait_edge(e0 + 10 * NBITS * 4);
        chk("b2b_busy_last_cycle", 32'(busy), 32'd1);
        step();
        chk("b2b_busy_fall_no_gap", 32'(busy), 32'd0);
        wait_idle(600);
        chk("b2b_frame_count", 32'(frames - f0), 32'd10);

        // clk_div of 0 is clamped to 2-cycle bits
        f0 = frames;
        clk_div = DIV_W'(0);
        push1(8'h3C, 2, e0);
        wait_edge(e0 + NBITS * 2);
        chk("clamp_busy_last_cycle", 32'(busy), 32'd1);
        step();
        chk("clamp_busy_fall", 32'(busy), 32'd0);
        wait_idle(100);
        chk("clamp_frame_count", 32'(frames - f0), 32'd1);

        // Divisor change mid-frame only affects the following frame
        f0 = frames;
        clk_div = DIV_W'(4);
        push1(8'h5A, 4, e0);
        push1(8'hC3, 6, guard);
        wait_edge(e0 + 10);
        clk_div = DIV_W'(6);
        wait_edge(e0 + NBITS * 10);
        chk("divchg_busy_last_cycle", 32'(busy), 32'd1);
        step();
        chk("divchg_busy_fall", 32'(busy), 32'd0);
        wait_idle(300);
        chk("divchg_frame_count", 32'(frames - f0), 32'd2);

        // Reset in the middle of a frame with bytes still queued
        mon_en  = 1'b0;
        clk_div = DIV_W'(4);
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        repeat (3) step();
        tx_valid = 1'b0;
        repeat (10) step();
        chk("midrst_busy_before", 32'(busy), 32'd1);
        chk("midrst_level_before", 32'(fifo_level), 32'd2);
        chk("midrst_tx_low_before", 32'(tx), 32'd0);
        #5;
        rst = 1'b1;
        #1;
        chk("midrst_tx_high", 32'(tx), 32'd1);
        chk("midrst_level_zero", 32'(fifo_level), 32'd0);
        chk("midrst_busy_low", 32'(busy), 32'd0);
        chk("midrst_ready_high", 32'(tx_ready), 32'd1);
        step();
        step();
        rst = 1'b0;
        step();
        step();
        chk("post_rst_tx_idle", 32'(tx), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
